// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, a, b, carry_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, a, b, carry_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice iterated WIDTH times, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a - b via the sub request bit.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             bit_s;
    logic             carry_s;
    logic             last_s;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign carry_s = (a_sh_q[0] & b_sh_q[0])
                   | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_s  = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; carry_out then reads as "no borrow".
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub | bus.carry_in;
`else
    assign b_load = bus.b;
    assign c_load = bus.carry_in;
`endif

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        co_d        = co_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d     = bus.a;
                    b_sh_d     = b_load;
                    c_d        = c_load;
                    cnt_d      = '0;
                    state_d    = S_ADD;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ADD: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_s, res_q[WIDTH-1:1]};
                c_d    = carry_s;
                cnt_d  = cnt_q + 1'b1;
                if (last_s) begin
                    co_d        = carry_s;
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            co_q        <= co_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = res_q;
    assign bus.carry_out = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH = 8).
// With SERIAL_ADDER_SUB_EN defined the subtract vectors are also run.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns edges waited and busy samples seen.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = bus.busy ? 1 : 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
            if (bus.busy) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic eco);
        int n;
        int nb;
        bus.a = a;
        bus.b = b;
        bus.carry_in = cin;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.carry_in = ~cin;
        chk({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
        wait_done(n, nb);
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(W));
        chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.carry_out), 64'(eco));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int n;
        int nb;
        int k;
        int acc;
        int cyc;
        int last;
        int prev_busy;
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic         pc [3];
        logic [W-1:0] ps [3];
        logic         pco [3];

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.carry_out), 64'd0);
        rst_n = 1'b1;
        step();

        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("addff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

        // Backpressure: result held while new operands wait.
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.a = 8'h01;
        bus.b = 8'h02;
        wait_done(n, nb);
        chk("bp_latency", 64'(n), 64'(W));
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", 64'(bus.sum), 64'h46);
            chk("bp_cout", 64'(bus.carry_out), 64'd0);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_idle_rdy", 64'(bus.in_ready), 64'd1);
        chk("bp_idle_busy", 64'(bus.busy), 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("bp_accept", 64'(bus.busy), 64'd1);
        wait_done(n, nb);
        chk("bp2_latency", 64'(n), 64'(W));
        chk("bp2_sum", 64'(bus.sum), 64'h03);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Asynchronous reset during the third ADD cycle.
        bus.a = 8'h77;
        bus.b = 8'h11;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        chk("ar_busy", 64'(bus.busy), 64'd0);
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_sum", 64'(bus.sum), 64'd0);
        chk("ar_cout", 64'(bus.carry_out), 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        run_op("add0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Back-to-back with both handshakes held high.
        pa[0] = 8'h10; pb[0] = 8'h20; pc[0] = 1'b0;
        ps[0] = 8'h30; pco[0] = 1'b0;
        pa[1] = 8'h80; pb[1] = 8'h80; pc[1] = 1'b1;
        ps[1] = 8'h01; pco[1] = 1'b1;
        pa[2] = 8'hAA; pb[2] = 8'h55; pc[2] = 1'b0;
        ps[2] = 8'hFF; pco[2] = 1'b0;
        bus.a = pa[0];
        bus.b = pb[0];
        bus.carry_in = pc[0];
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        k = 0;
        acc = 0;
        cyc = 0;
        last = 0;
        prev_busy = 0;
        while (k < 3 && cyc < 60) begin
            step();
            cyc++;
            if (bus.busy && prev_busy == 0) begin
                acc++;
                if (acc < 3) begin
                    bus.a = pa[acc];
                    bus.b = pb[acc];
                    bus.carry_in = pc[acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            prev_busy = bus.busy ? 1 : 0;
            if (bus.out_valid) begin
                chk("b2b_sum", 64'(bus.sum), 64'(ps[k]));
                chk("b2b_cout", 64'(bus.carry_out), 64'(pco[k]));
                if (k > 0) chk("b2b_spacing", 64'(cyc - last), 64'(W + 2));
                last = cyc;
                k++;
            end
        end
        chk("b2b_count", 64'(k), 64'd3);
        chk("b2b_accepts", 64'(acc), 64'd3);
        bus.in_valid = 1'b0;
        step();
        step();
        bus.out_ready = 1'b0;
        chk("b2b_idle", 64'(bus.in_ready), 64'd1);

`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b1;
        run_op("sub1001", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op("sub0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        bus.sub = 1'b0;
        run_op("nosub", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
